fma16_issue_ctrl: RTL and testbench

Sequencer and arbiter that shares one combinational fma16 datapath between NREQ requesters. It accepts operand/op bundles over valid/ready and grants them round-robin. Operands are held stable for LAT cycles while the core settles, then result and flags are captured into a response buffer. Exception flags are accumulated into a sticky RISC-V-style fflags register.

---
 rtl/fma16_pkg.sv | 42 ++++
 rtl/fma16_rr_arb.sv | 40 ++++
 rtl/fma16_issue_ctrl.sv | 167 ++++++++++++++++
 tb/tb_fma16_issue_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fma16_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fma16_pkg : shared state encoding, op/flag bit positions, helpers
// Revision  : 1.0
// ---------------------------------------------------------------------------
package fma16_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Bit positions inside the 4-bit {mul, add, negp, negz} op field
    localparam int OP_MUL  = 3;
    localparam int OP_ADD  = 2;
    localparam int OP_NEGP = 1;
    localparam int OP_NEGZ = 0;

    // Bit positions inside the 5-bit {nv, dz, of, uf, nx} sticky field
    localparam int FL_NV = 4;
    localparam int FL_DZ = 3;
    localparam int FL_OF = 2;
    localparam int FL_UF = 1;
    localparam int FL_NX = 0;

    localparam logic [15:0] CANON_NAN = 16'h7E00;

    // Core reports {nv, of, uf, nx}; the sticky register has no dz source.
    function automatic logic [4:0] to_fflags(input logic [3:0] f);
        logic [4:0] v;
        v        = '0;
        v[FL_NV] = f[3];
        v[FL_DZ] = 1'b0;
        v[FL_OF] = f[2];
        v[FL_UF] = f[1];
        v[FL_NX] = f[0];
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fma16_rr_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fma16_rr_arb : combinational round-robin pick, first valid at/after ptr
// Revision     : 1.0
// ---------------------------------------------------------------------------
module fma16_rr_arb #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  index,
    output logic            found
);

    always_comb begin
        int              cand;
        logic [IDW-1:0]  idx;
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = 0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            idx = IDW'(cand);
            if (!found && valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                index      = idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fma16_issue_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fma16_issue_ctrl : round-robin issue/capture sequencer for a shared fma16
// core with sticky fflags. Optional counters: FMA16_PERF_CNT_EN.
// Revision         : 1.0
// ---------------------------------------------------------------------------
module fma16_issue_ctrl
    import fma16_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int LAT  = 2,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CNTW = (LAT > 1) ? $clog2(LAT) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_x,
    input  logic [16*NREQ-1:0]   req_y,
    input  logic [16*NREQ-1:0]   req_z,
    input  logic [4*NREQ-1:0]    req_op,
    input  logic [2*NREQ-1:0]    req_rm,
    output logic [15:0]          core_x,
    output logic [15:0]          core_y,
    output logic [15:0]          core_z,
    output logic [3:0]           core_op,
    output logic [1:0]           core_rm,
    input  logic [15:0]          core_result,
    input  logic [3:0]           core_flags,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_result,
    output logic [3:0]           rsp_flags,
    input  logic                 fflags_clr,
    output logic [4:0]           fflags
`ifdef FMA16_PERF_CNT_EN
    ,
    output logic [15:0]          perf_ops,
    output logic [15:0]          perf_stall
`endif
);

    state_t          state, state_next;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  gnt_id;
    logic [CNTW-1:0] cnt;
    logic [NREQ-1:0] arb_gnt;
    logic [IDW-1:0]  arb_idx;
    logic            arb_found;
    logic            accept;
    logic            capture;
    logic            handshake;

    fma16_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_gnt),
        .index (arb_idx),
        .found (arb_found)
    );

    assign handshake = rsp_valid & rsp_ready;
    assign rsp_id    = gnt_id;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        accept     = 1'b0;
        capture    = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (arb_found) begin
                    req_ready  = arb_gnt;
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Grant must not leak out while reset is held with requests pending
        if (!reset_n) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_x     <= '0;
            core_y     <= '0;
            core_z     <= '0;
            core_op    <= '0;
            core_rm    <= '0;
            gnt_id     <= '0;
            cnt        <= '0;
            rr_ptr     <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            fflags     <= '0;
        end else begin
            if (accept) begin
                core_x  <= req_x[arb_idx*16 +: 16];
                core_y  <= req_y[arb_idx*16 +: 16];
                core_z  <= req_z[arb_idx*16 +: 16];
                core_op <= req_op[arb_idx*4 +: 4];
                core_rm <= req_rm[arb_idx*2 +: 2];
                gnt_id  <= arb_idx;
                cnt     <= CNTW'(LAT - 1);
            end else if (state == EXEC && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (capture) begin
                rsp_result <= core_result;
                rsp_flags  <= core_flags;
            end
            if (handshake) begin
                rr_ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            end
            // A clear coinciding with a handshake keeps only the new flags
            fflags <= (fflags_clr ? 5'b0 : fflags) |
                      (handshake ? to_fflags(rsp_flags) : 5'b0);
        end
    end

`ifdef FMA16_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (handshake && perf_ops != 16'hFFFF) begin
                perf_ops <= perf_ops + 1'b1;
            end
            if (rsp_valid && !rsp_ready && perf_stall != 16'hFFFF) begin
                perf_stall <= perf_stall + 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fma16_issue_ctrl.sv
`default_nettype none
// Bench for fma16_issue_ctrl: vector table through a response scoreboard,
// plus hand sequences for arbitration, stall, sticky-flag and reset corners.
module tb_fma16_issue_ctrl;

    localparam int NREQ = 2;
    localparam int LAT  = 2;

    typedef struct {
        int          id;
        logic [15:0] x, y, z;
        logic [3:0]  op;
        logic [1:0]  rm;
        logic [15:0] res;
        logic [3:0]  fl;
    } vec_t;

    typedef struct {
        int          id;
        logic [15:0] res;
        logic [3:0]  fl;
    } exp_t;

    logic                clk;
    logic                reset_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [16*NREQ-1:0]  req_x, req_y, req_z;
    logic [4*NREQ-1:0]   req_op;
    logic [2*NREQ-1:0]   req_rm;
    logic [15:0]         core_x, core_y, core_z;
    logic [3:0]          core_op;
    logic [1:0]          core_rm;
    logic [15:0]         core_result;
    logic [3:0]          core_flags;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [0:0]          rsp_id;
    logic [15:0]         rsp_result;
    logic [3:0]          rsp_flags;
    logic                fflags_clr;
    logic [4:0]          fflags;
`ifdef FMA16_PERF_CNT_EN
    logic [15:0]         perf_ops, perf_stall;
`endif

    fma16_issue_ctrl #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_z       (req_z),
        .req_op      (req_op),
        .req_rm      (req_rm),
        .core_x      (core_x),
        .core_y      (core_y),
        .core_z      (core_z),
        .core_op     (core_op),
        .core_rm     (core_rm),
        .core_result (core_result),
        .core_flags  (core_flags),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_flags   (rsp_flags),
        .fflags_clr  (fflags_clr),
        .fflags      (fflags)
`ifdef FMA16_PERF_CNT_EN
        ,
        .perf_ops    (perf_ops),
        .perf_stall  (perf_stall)
`endif
    );

    // Toy fma16 core: two exact special cases, otherwise a hash of all inputs
    always_comb begin
        core_result = core_x ^ core_y ^ core_z ^ {core_op, core_rm, 10'h000};
        core_flags  = core_z[3:0];
        if (core_op[3] && core_x == 16'h7C00 && core_y == 16'h0000) begin
            core_result = 16'h7E00;
            core_flags  = 4'b1000;
        end else if (core_op[3] && core_x == 16'h3C00 && core_z == 16'h0000) begin
            core_result = core_y;
            core_flags  = 4'b0000;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          n_hs     = 0;
    exp_t        sb[$];
    logic [15:0] exp_res[NREQ];
    logic [3:0]  exp_fl[NREQ];
    logic [4:0]  flm;
    logic [1:0]  s_gnt, s_rdy;
    logic        s_rspv, s_hs;
    logic [0:0]  s_id;
    logic [15:0] s_res;
    logic [3:0]  s_fl;
    vec_t        tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        s_gnt  = req_valid & req_ready;
        s_rdy  = req_ready;
        s_rspv = rsp_valid;
        s_hs   = rsp_valid & rsp_ready;
        s_id   = rsp_id;
        s_res  = rsp_result;
        s_fl   = rsp_flags;
        if (!reset_n) begin
            flm = '0;
            sb.delete();
        end else begin
            check("fflags", 32'(fflags), 32'(flm));
            check("gnt_onehot0", 32'($onehot0(req_ready)), 32'd1);
            if (sb.size() == 0) check("no_stale_rsp", 32'(rsp_valid), 32'd0);
            for (int g = 0; g < NREQ; g++) begin
                if (s_gnt[g]) begin
                    e.id  = g;
                    e.res = exp_res[g];
                    e.fl  = exp_fl[g];
                    sb.push_back(e);
                end
            end
            if (s_hs && sb.size() != 0) begin
                e = sb.pop_front();
                n_hs++;
                check("rsp_id", 32'(s_id), 32'(e.id));
                check("rsp_result", 32'(s_res), 32'(e.res));
                check("rsp_flags", 32'(s_fl), 32'(e.fl));
                flm = (fflags_clr ? 5'b0 : flm) | {e.fl[3], 1'b0, e.fl[2:0]};
            end else if (fflags_clr) begin
                flm = '0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_req(input int g, input vec_t v);
        req_x[g*16 +: 16] = v.x;
        req_y[g*16 +: 16] = v.y;
        req_z[g*16 +: 16] = v.z;
        req_op[g*4 +: 4]  = v.op;
        req_rm[g*2 +: 2]  = v.rm;
        exp_res[g]        = v.res;
        exp_fl[g]         = v.fl;
    endtask

    task automatic scramble(input int g);
        req_x[g*16 +: 16] = 16'($urandom);
        req_y[g*16 +: 16] = 16'($urandom);
        req_z[g*16 +: 16] = 16'($urandom);
        req_op[g*4 +: 4]  = 4'($urandom);
        req_rm[g*2 +: 2]  = 2'($urandom);
    endtask

    task automatic wait_grant(input int g, input string name);
        bit seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            seen = s_gnt[g];
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic run_op(input vec_t v);
        bit seen = 0;
        int k    = 0;
        set_req(v.id, v);
        req_valid[v.id] = 1'b1;
        wait_grant(v.id, "op_grant");
        req_valid[v.id] = 1'b0;
        scramble(v.id);
        while (!seen && k < 20) begin
            step();
            k++;
            seen = s_rspv;
        end
        check("op_latency", 32'(k), 32'(LAT + 1));
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++) step();
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int  gid[4];
        int  gcyc[4];
        int  n;
        bit  seen;
        vec_t v;

        tbl[0] = '{0, 16'h3C00, 16'h4000, 16'h0000, 4'b1000, 2'b00, 16'h4000, 4'b0000};
        tbl[1] = '{1, 16'h1234, 16'h0F0F, 16'h0001, 4'b0100, 2'b01, 16'h593A, 4'b0001};
        tbl[2] = '{0, 16'h7C00, 16'h0000, 16'h0000, 4'b1000, 2'b00, 16'h7E00, 4'b1000};
        tbl[3] = '{1, 16'hABCD, 16'h0000, 16'h0004, 4'b0010, 2'b10, 16'h83C9, 4'b0100};
        tbl[4] = '{0, 16'h3C00, 16'h5555, 16'h0002, 4'b0001, 2'b11, 16'h7557, 4'b0010};
        tbl[5] = '{1, 16'h3C00, 16'h1111, 16'h0000, 4'b1000, 2'b00, 16'h1111, 4'b0000};

        reset_n    = 1'b0;
        req_valid  = 2'b11;
        req_x      = '0;
        req_y      = '0;
        req_z      = '0;
        req_op     = '0;
        req_rm     = '0;
        rsp_ready  = 1'b1;
        fflags_clr = 1'b0;
        flm        = '0;
        exp_res[0] = '0; exp_res[1] = '0;
        exp_fl[0]  = '0; exp_fl[1]  = '0;
        step();
        step();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_fflags", 32'(fflags), 32'd0);
        check("rst_core_x", 32'(core_x), 32'd0);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        req_valid = 2'b00;
        reset_n   = 1'b1;
        step();

        // Two requesters always pending: alternate grants every LAT+2 cycles
        set_req(0, tbl[0]);
        set_req(1, tbl[1]);
        req_valid = 2'b11;
        n = 0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            step();
            if (s_gnt != 2'b00) begin
                gid[n]  = s_gnt[1] ? 1 : 0;
                gcyc[n] = cyc;
                n++;
            end
        end
        req_valid = 2'b00;
        check("rr_count", 32'(n), 32'd4);
        for (int i = 0; i < n; i++) begin
            check("rr_order", 32'(gid[i]), 32'(i % 2));
            if (i > 0) check("rr_interval", 32'(gcyc[i] - gcyc[i-1]), 32'(LAT + 2));
        end
        drain();

        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i]);
        end
        drain();

        // Response back-pressure with another requester waiting
        set_req(0, tbl[4]);
        set_req(1, tbl[1]);
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        wait_grant(0, "stall_grant");
        scramble(0);
        req_valid = 2'b10;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            seen = s_rspv;
        end
        check("stall_rsp_seen", 32'(seen), 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            check("stall_valid", 32'(s_rspv), 32'd1);
            check("stall_id", 32'(s_id), 32'd0);
            check("stall_result", 32'(s_res), 32'(tbl[4].res));
            check("stall_flags", 32'(s_fl), 32'(tbl[4].fl));
            check("stall_req_ready", 32'(s_rdy), 32'd0);
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        step();
        check("stall_release_hs", 32'(s_hs), 32'd1);
`ifdef FMA16_PERF_CNT_EN
        check("perf_stall", 32'(perf_stall), 32'd5);
        check("perf_ops", 32'(perf_ops), 32'(n_hs));
`endif

        // Sticky flags: clear, accumulate, clear coinciding with a handshake
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        check("fflags_cleared", 32'(fflags), 32'd0);
        run_op(tbl[2]);
        check("fflags_nv", 32'(fflags), 32'b10000);
        v = '{1, 16'h1234, 16'h0000, 16'h0001, 4'b0000, 2'b00, 16'h1235, 4'b0001};
        run_op(v);
        check("fflags_nv_nx", 32'(fflags), 32'b10001);
        v = '{0, 16'h1234, 16'h0000, 16'h0004, 4'b0000, 2'b00, 16'h1230, 4'b0100};
        set_req(0, v);
        req_valid = 2'b01;
        wait_grant(0, "clr_grant");
        req_valid = 2'b00;
        scramble(0);
        step();
        step();
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        check("clr_hs_same_cycle", 32'(s_hs), 32'd1);
        check("fflags_clr_plus_of", 32'(fflags), 32'b00100);

        // Asynchronous reset in EXEC drops the op and clears sticky state
        set_req(1, tbl[5]);
        req_valid = 2'b10;
        wait_grant(1, "arst_grant");
        req_valid = 2'b00;
        scramble(1);
        step();
        set_req(0, tbl[0]);
        set_req(1, tbl[5]);
        req_valid = 2'b11;
        reset_n   = 1'b0;
        #1;
        check("arst_fflags", 32'(fflags), 32'd0);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_req_ready", 32'(req_ready), 32'd0);
        check("arst_core_x", 32'(core_x), 32'd0);
        step();
        step();
        req_valid = 2'b00;
        reset_n   = 1'b1;
        for (int k = 0; k < 4; k++) step();
        req_valid = 2'b11;
        step();
        check("arst_rr_restart", 32'(s_gnt), 32'b01);
        req_valid = 2'b00;
        scramble(0);
        scramble(1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
